// File: rtl/seq_nibble_adder_pkg.sv
// Shared definitions for seq_nibble_adder: FSM state encoding and nibble width.
package seq_nibble_adder_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_nibble_adder_add4.sv
// nibble_add4: combinational 4-bit ripple-carry adder built from full-adder equations.
module nibble_add4
    import seq_nibble_adder_pkg::*;
(
    input  logic [NIB-1:0] a4,
    input  logic [NIB-1:0] b4,
    input  logic           ci,
    output logic [NIB-1:0] s4,
    output logic           co
);

    logic [NIB:0] c;

    always_comb begin
        c    = '0;
        s4   = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < NIB; i++) begin
            s4[i]  = a4[i] ^ b4[i] ^ c[i];
            c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
        end
        co = c[NIB];
    end

endmodule

// File: rtl/seq_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared 4-bit ripple adder.
// Optional macro SEQ_ADD_OVF_EN adds a signed-overflow output ovf.
module seq_nibble_adder
    import seq_nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTEP = WIDTH / NIB;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [SW-1:0]    step;
    logic [NIB-1:0]   s4;
    logic             co;

    nibble_add4 u_add (
        .a4 (a_sh[NIB-1:0]),
        .b4 (b_sh[NIB-1:0]),
        .ci (carry),
        .s4 (s4),
        .co (co)
    );

`ifdef SEQ_ADD_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // Handshake flags are registered alongside state so they change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        step     <= '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SEQ_ADD_OVF_EN
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    sum_sh <= {s4, sum_sh[WIDTH-1:NIB]};
                    a_sh   <= a_sh >> NIB;
                    b_sh   <= b_sh >> NIB;
                    carry  <= co;
                    step   <= step + SW'(1);
                    if (step == LAST_STEP) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign sum  = sum_sh;
    assign cout = carry;

`ifdef SEQ_ADD_OVF_EN
    assign ovf = out_valid && (a_msb == b_msb) && (sum_sh[WIDTH-1] != a_msb);
`endif

endmodule
